// File: rtl/cla_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cla_pkg
// Description : Shared constants, types and helpers for the pipelined
//               carry-lookahead adder (cla_pipe_adder) and its 4-bit slice.
// Revision    : 1.0 - initial release
// ============================================================================
package cla_pkg;

  // Width of one carry-lookahead slice in bits.
  localparam int SLICE_W = 4;

  // Number of pipeline stages for a given operand width and stage size.
  function automatic int cla_stages(input int width, input int slices_per_stage);
    return width / (SLICE_W * slices_per_stage);
  endfunction

  // Control part of a stage payload. The partial sum and the not-yet-used
  // operand bits shrink/grow by one stage width per stage, so they are
  // declared per stage next to this struct with their exact widths.
  typedef struct packed {
    logic valid;  // stage holds a real beat (0 = bubble)
    logic carry;  // carry out of the highest bit computed so far
  } stage_ctl_t;

endpackage : cla_pkg
`default_nettype wire

// File: rtl/cla4_slice.sv
`default_nettype none
// ============================================================================
// Module      : cla4_slice
// Description : Combinational 4-bit carry-lookahead slice. Produces the sum,
//               group generate/propagate for chaining, the slice carry out,
//               and the carry into bit 3 (for MSB overflow detection).
// Revision    : 1.0 - initial release
// ============================================================================
module cla4_slice (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       g,
  output logic       p,
  output logic       cout,
  output logic       c3
);

  logic [3:0] w_gi;
  logic [3:0] w_pi;
  logic [3:0] w_c;

  // Bit generate/propagate, flattened lookahead carries and group terms.
  always_comb begin
    w_gi   = a & b;
    w_pi   = a ^ b;
    w_c[0] = cin;
    w_c[1] = w_gi[0] | (w_pi[0] & cin);
    w_c[2] = w_gi[1] | (w_pi[1] & w_gi[0]) | (w_pi[1] & w_pi[0] & cin);
    w_c[3] = w_gi[2] | (w_pi[2] & w_gi[1]) | (w_pi[2] & w_pi[1] & w_gi[0])
           | (w_pi[2] & w_pi[1] & w_pi[0] & cin);
    g      = w_gi[3] | (w_pi[3] & w_gi[2]) | (w_pi[3] & w_pi[2] & w_gi[1])
           | (w_pi[3] & w_pi[2] & w_pi[1] & w_gi[0]);
    p      = &w_pi;
    cout   = g | (p & cin);
    c3     = w_c[3];
    sum    = w_pi ^ w_c;
  end

endmodule : cla4_slice
`default_nettype wire

// File: rtl/cla_pipe_adder.sv
`default_nettype none
// ============================================================================
// Module      : cla_pipe_adder
// Description : Pipelined carry-lookahead adder/subtractor. Each stage adds
//               SLICES_PER_STAGE 4-bit slices using the carry registered by
//               the previous stage; upper operand bits and lower sum bits
//               travel alongside in skew registers. Valid/ready handshake,
//               latency STAGES, throughput one beat per cycle.
//               Optional macro CLA_PIPE_SAT_EN: saturate the sum on signed
//               overflow in the final stage (no latency change).
// Revision    : 1.0 - initial release
// ============================================================================
module cla_pipe_adder
  import cla_pkg::*;
#(
  parameter int WIDTH            = 16,
  parameter int SLICES_PER_STAGE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c0,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);

  localparam int SW     = SLICE_W * SLICES_PER_STAGE;
  localparam int STAGES = cla_stages(WIDTH, SLICES_PER_STAGE);

  // Reject widths that do not split into whole stages.
  if ((SLICES_PER_STAGE < 1) || (WIDTH < SW) || ((WIDTH % SW) != 0)) begin : g_param_check
    $error("cla_pipe_adder: WIDTH (%0d) must be a positive multiple of 4*SLICES_PER_STAGE (%0d)",
           WIDTH, SW);
  end

  logic             w_stall;
  logic             w_accept;
  logic [WIDTH-1:0] w_b_eff;
  logic             w_cin_eff;

  // Final-stage (output) registers.
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_sum_q,   out_sum_d;
  logic             carry_out_q, carry_out_d;
  logic             overflow_q,  overflow_d;

  // Handshake and effective operands: subtract is A + ~B + 1.
  always_comb begin
    w_stall   = out_valid_q & ~out_ready;
    in_ready  = ~w_stall;
    w_accept  = in_valid & ~w_stall;
    w_b_eff   = sub ? ~b : b;
    w_cin_eff = sub | c0;
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO  = k * SW;      // lowest bit handled by this stage
    localparam int RIN = WIDTH - LO;  // operand bits still pending on entry
    localparam int HI  = LO + SW;     // sum bits known after this stage

    logic [RIN-1:0] w_a_in;
    logic [RIN-1:0] w_b_in;
    logic           w_cin;
    logic           w_v_in;
    logic [SW-1:0]  w_seg;
    logic [HI-1:0]  w_acc;
    logic           w_cout;

    if (k == 0) begin : g_src
      assign w_a_in = a;
      assign w_b_in = w_b_eff;
      assign w_cin  = w_cin_eff;
      assign w_v_in = w_accept;
      assign w_acc  = w_seg;
    end else begin : g_src
      assign w_a_in = g_stage[k-1].g_reg.a_rem_q;
      assign w_b_in = g_stage[k-1].g_reg.b_rem_q;
      assign w_cin  = g_stage[k-1].g_reg.ctl_q.carry;
      assign w_v_in = g_stage[k-1].g_reg.ctl_q.valid;
      assign w_acc  = {w_seg, g_stage[k-1].g_reg.sum_q};
    end

    // Slices inside a stage are chained through their group G/P terms.
    for (genvar j = 0; j < SLICES_PER_STAGE; j++) begin : g_slice
      logic w_ci;
      logic w_g;
      logic w_p;
      logic w_co;
      logic w_c3;
      logic w_cn;

      if (j == 0) begin : g_ci
        assign w_ci = w_cin;
      end else begin : g_ci
        assign w_ci = g_slice[j-1].w_cn;
      end

      cla4_slice u_slice (
        .a    (w_a_in[j*SLICE_W +: SLICE_W]),
        .b    (w_b_in[j*SLICE_W +: SLICE_W]),
        .cin  (w_ci),
        .sum  (w_seg[j*SLICE_W +: SLICE_W]),
        .g    (w_g),
        .p    (w_p),
        .cout (w_co),
        .c3   (w_c3)
      );

      assign w_cn = w_g | (w_p & w_ci);

      // The slice's own carry out and bit-3 carry must agree with the chain.
      a_slice_consistent : assert property (@(posedge clk) disable iff (!rst_n)
        (w_co == w_cn) &&
        (w_seg[j*SLICE_W+3] == (w_a_in[j*SLICE_W+3] ^ w_b_in[j*SLICE_W+3] ^ w_c3)));
    end

    assign w_cout = g_slice[SLICES_PER_STAGE-1].w_cn;

    if (k < STAGES - 1) begin : g_reg
      stage_ctl_t         ctl_q,   ctl_d;
      logic [HI-1:0]      sum_q,   sum_d;
      logic [RIN-SW-1:0]  a_rem_q, a_rem_d;
      logic [RIN-SW-1:0]  b_rem_q, b_rem_d;

      // Advance with the pipe; payload only reloads when a real beat arrives.
      always_comb begin
        ctl_d   = ctl_q;
        sum_d   = sum_q;
        a_rem_d = a_rem_q;
        b_rem_d = b_rem_q;
        if (!w_stall) begin
          ctl_d.valid = w_v_in;
          if (w_v_in) begin
            ctl_d.carry = w_cout;
            sum_d       = w_acc;
            a_rem_d     = w_a_in[RIN-1:SW];
            b_rem_d     = w_b_in[RIN-1:SW];
          end
        end
      end

      // Intermediate stage registers, cleared on reset.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ctl_q   <= '0;
          sum_q   <= '0;
          a_rem_q <= '0;
          b_rem_q <= '0;
        end else begin
          ctl_q   <= ctl_d;
          sum_q   <= sum_d;
          a_rem_q <= a_rem_d;
          b_rem_q <= b_rem_d;
        end
      end
    end else begin : g_out
      logic             w_ovf;
      logic [WIDTH-1:0] w_sum_sel;
`ifdef CLA_PIPE_SAT_EN
      localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
      localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};
`endif

      // Overflow from MSB carries, optional clamp, then output register update.
      always_comb begin
        w_ovf     = g_slice[SLICES_PER_STAGE-1].w_c3 ^ w_cout;
        w_sum_sel = w_acc;
`ifdef CLA_PIPE_SAT_EN
        // Sign of A picks the rail: non-negative A can only overflow upward.
        if (w_ovf) begin
          w_sum_sel = w_a_in[SW-1] ? SAT_MIN : SAT_MAX;
        end
`endif
        out_valid_d = out_valid_q;
        out_sum_d   = out_sum_q;
        carry_out_d = carry_out_q;
        overflow_d  = overflow_q;
        if (!w_stall) begin
          out_valid_d = w_v_in;
          if (w_v_in) begin
            out_sum_d   = w_sum_sel;
            carry_out_d = w_cout;
            overflow_d  = w_ovf;
          end
        end
      end

      // Output registers, cleared on reset.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          out_valid_q <= 1'b0;
          out_sum_q   <= '0;
          carry_out_q <= 1'b0;
          overflow_q  <= 1'b0;
        end else begin
          out_valid_q <= out_valid_d;
          out_sum_q   <= out_sum_d;
          carry_out_q <= carry_out_d;
          overflow_q  <= overflow_d;
        end
      end
    end
  end

  assign out_valid = out_valid_q;
  assign sum       = out_sum_q;
  assign carry_out = carry_out_q;
  assign overflow  = overflow_q;

endmodule : cla_pipe_adder
`default_nettype wire

// File: tb/tb_cla_pipe_adder.sv
`default_nettype none
// ============================================================================
// Module      : tb_cla_pipe_adder
// Description : Directed self-checking bench for cla_pipe_adder with the
//               default WIDTH=16, SLICES_PER_STAGE=1 (latency 4). Honours
//               CLA_PIPE_SAT_EN for the saturated expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cla_pipe_adder;

  logic        clk       = 1'b0;
  logic        rst_n     = 1'b0;
  logic        in_valid  = 1'b0;
  logic        in_ready;
  logic [15:0] a         = '0;
  logic [15:0] b         = '0;
  logic        c0        = 1'b0;
  logic        sub       = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] sum;
  logic        carry_out;
  logic        overflow;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  cla_pipe_adder #(
    .WIDTH            (16),
    .SLICES_PER_STAGE (1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .c0        (c0),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .carry_out (carry_out),
    .overflow  (overflow)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [15:0] av, input logic [15:0] bv, input logic cv, input logic sv);
    in_valid = 1'b1;
    a        = av;
    b        = bv;
    c0       = cv;
    sub      = sv;
    tick();
  endtask

  task automatic check_out(input string tag, input logic [15:0] es, input logic ec, input logic eo);
    check({tag, ".valid"}, out_valid, 32'd1);
    check({tag, ".sum"},   sum,       es);
    check({tag, ".cout"},  carry_out, ec);
    check({tag, ".ovf"},   overflow,  eo);
  endtask

  initial begin
    logic [15:0] exp_c;
    logic [15:0] exp_d;
    int          src;
    int          snk;
    int          seen;

`ifdef CLA_PIPE_SAT_EN
    exp_c = 16'h7FFF;
    exp_d = 16'h8000;
`else
    exp_c = 16'h8000;
    exp_d = 16'h7FFF;
`endif

    // Reset state
    #12;
    check("rst.valid", out_valid, 0);
    check("rst.sum",   sum,       0);
    check("rst.cout",  carry_out, 0);
    check("rst.ovf",   overflow,  0);
    check("rst.ready", in_ready,  1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Single beat, latency 4
    beat(16'h1234, 16'h0FCC, 1'b1, 1'b0);
    in_valid = 1'b0;
    check("t1.lat1", out_valid, 0);
    tick();
    check("t1.lat2", out_valid, 0);
    tick();
    check("t1.lat3", out_valid, 0);
    tick();
    check_out("t1", 16'h2201, 1'b0, 1'b0);

    // Wrap-around and overflow, back to back
    beat(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    beat(16'h0000, 16'h0001, 1'b0, 1'b1);
    beat(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    beat(16'h8000, 16'h0001, 1'b0, 1'b1);
    in_valid = 1'b0;
    check_out("t2.wrap_add", 16'h0000, 1'b1, 1'b0);
    tick();
    check_out("t2.wrap_sub", 16'hFFFF, 1'b0, 1'b0);
    tick();
    check_out("t2.ovf_pos",  exp_c,    1'b0, 1'b1);
    tick();
    check_out("t2.ovf_neg",  exp_d,    1'b1, 1'b1);

    // in_valid 1,0,1 gives out_valid 1,0,1
    beat(16'h0001, 16'h0002, 1'b0, 1'b0);
    in_valid = 1'b0;
    tick();
    beat(16'h00FF, 16'h0F01, 1'b0, 1'b0);
    in_valid = 1'b0;
    tick();
    check_out("t3.first", 16'h0003, 1'b0, 1'b0);
    tick();
    check("t3.bubble", out_valid, 0);
    tick();
    check_out("t3.second", 16'h1000, 1'b0, 1'b0);
    tick();

    // Stream of 8 beats with out_ready low in cycles 6..8
    src = 0;
    snk = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      in_valid  = (src < 8);
      a         = 16'(16'h0101 * src);
      b         = 16'h0010;
      c0        = 1'b0;
      sub       = 1'b0;
      out_ready = !(cyc >= 6 && cyc <= 8);
      #1;
      if (cyc >= 4 && cyc <= 14) check($sformatf("t4.valid%0d", cyc), out_valid, 1);
      if (cyc == 15)             check("t4.drained", out_valid, 0);
      if (cyc >= 6 && cyc <= 8)  check($sformatf("t4.stall%0d", cyc), in_ready, 0);
      else if (cyc <= 10)        check($sformatf("t4.ready%0d", cyc), in_ready, 1);
      if (out_valid && out_ready) begin
        check($sformatf("t4.sum%0d", snk), sum, 16'(16'h0101 * snk + 16'h0010));
        snk++;
      end
      if (in_valid && in_ready) src++;
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("t4.sent", src, 8);
    check("t4.recv", snk, 8);

    // Async reset with three beats in flight
    for (int i = 0; i < 6; i++) begin
      beat(16'(16'hF000 + i), 16'h1000, 1'b0, 1'b0);
    end
    in_valid = 1'b0;
    check_out("t5.pre", 16'h0002, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5.rst.valid", out_valid, 0);
    check("t5.rst.sum",   sum,       0);
    check("t5.rst.cout",  carry_out, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (out_valid) seen++;
    end
    check("t5.no_stale", seen, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_cla_pipe_adder
`default_nettype wire

// File: doc/cla_pipe_adder.md
Name: cla_pipe_adder

Overview:
- Parametrised, pipelined carry-lookahead adder/subtractor built from 4-bit lookahead slices.
- Operands are split into stages of SLICES_PER_STAGE slices, with one register boundary per stage; the carry ripples stage to stage through registers.
- Valid/ready handshake on input and output; one new operation accepted per cycle when not stalled.
- Sits in the datapath as the wide-add successor to the fixed 4-bit combinational adder.

Parameters:
- WIDTH, 16, operand/sum width in bits; must be a multiple of 4*SLICES_PER_STAGE.
- SLICES_PER_STAGE, 1, 4-bit slices evaluated per pipeline stage.
- STAGES (derived, localparam), WIDTH/(4*SLICES_PER_STAGE), pipeline depth and latency.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand beat present
- in_ready  out  1  block accepts beat this cycle
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- c0  in  1  carry-in (add mode only)
- sub  in  1  1 = A-B, 0 = A+B+c0
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts result
- sum  out  WIDTH  result
- carry_out  out  1  carry out of MSB (subtract: 1 = no borrow)
- overflow  out  1  signed two's-complement overflow

Behaviour:
- Reset (async assert, sync-safe deassert): out_valid=0, sum=0, carry_out=0, overflow=0, all stage valid bits and data=0. In-flight operations are discarded, with no partial output.
- Stall: stall = out_valid & ~out_ready. in_ready = ~stall, combinational.
  - When not stalled, all stages advance together.
  - When stalled, every register holds, including stage data and valid bits.
- Accept: a beat transfers when in_valid & in_ready.
  - On transfer, stage 0 captures effective operands: b_eff = sub ? ~b : b, cin_eff = sub ? 1 : c0.
  - If in_valid=0 and not stalled, a bubble (valid=0) enters stage 0.
- Stage k (0..STAGES-1) computes bits [k*4S +: 4S] with lookahead over its slices, using the carry registered from stage k-1 (stage 0 uses cin_eff).
  - Lower result bits and not-yet-used upper operand bits travel in skew registers alongside.
- Latency: the result for a beat accepted at cycle t is presented with out_valid=1 at cycle t+STAGES, absent stalls. Throughput is 1/cycle.
- Final stage outputs:
  - carry_out = carry out of bit WIDTH-1.
  - overflow = carry into MSB XOR carry out of MSB.
  - sum = full WIDTH result.
- Output stays stable while stalled. Results leave in order; no reordering, no drop, no duplicate.
- Simultaneous in_valid and stall: the beat is not accepted, and the source holds it.
- Bubbles never raise out_valid. Output data under out_valid=0 is don't-care but must not be X after reset.
- Wrap-around: arithmetic is modulo 2^WIDTH. Examples: 0xFFFF+1 gives 0x0000 with carry_out=1; 0x0000-1 gives 0xFFFF with carry_out=0.
- Illegal parameter combinations (a non-multiple width) must raise an elaboration-time error.

Optional Feature:
- Macro CLA_PIPE_SAT_EN.
- Defined: when overflow=1, sum is clamped to signed max (0x7FF..F) if operand A was non-negative, else signed min (0x800..0). carry_out and overflow are reported unchanged. The clamp is applied in the final stage with no latency change.
- Undefined: sum wraps, and no clamp logic is present.

Decomposition:
- Shared package cla_pkg:
  - SLICE_W=4 constant.
  - Function computing STAGES from WIDTH/SLICES_PER_STAGE.
  - Struct typedef for a stage payload: valid, carry, partial sum, remaining operands.
- Sub-module cla4_slice (combinational):
  - Inputs: a[3:0], b[3:0], cin.
  - Outputs: sum[3:0], group generate, group propagate, cout, and carry into bit 3 (used for overflow on the top slice).
- Per-stage lookahead chains slices via G/P.

Test Plan (defaults WIDTH=16, SLICES_PER_STAGE=1, STAGES=4):
- a=0x1234, b=0x0FCC, c0=1, sub=0, out_ready=1 → 4 cycles later: sum=0x2201, carry_out=0, overflow=0.
- a=0xFFFF, b=0x0001, sub=0, c0=0 → sum=0x0000, carry_out=1, overflow=0. Next beat: sub=1, a=0x0000, b=0x0001 → sum=0xFFFF, carry_out=0.
- a=0x7FFF, b=0x0001, sub=0 → overflow=1, sum=0x8000; with CLA_PIPE_SAT_EN, sum=0x7FFF. a=0x8000, b=0x0001, sub=1 → overflow=1, sum=0x7FFF; with CLA_PIPE_SAT_EN, sum=0x8000.
- Back-to-back stream of 8 beats, with out_ready held 0 for 3 cycles mid-stream → in_ready=0 exactly while stalled, no beat lost or duplicated, results in order, and 1/cycle after release.
- in_valid toggled 1,0,1 → out_valid pattern 1,0,1 offset by 4 cycles.
- rst_n pulsed low with 3 beats in flight → outputs zero immediately (async), out_valid=0, and no stale result appears after release.
